mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WORD_IDX_W, default 10, word-index bits driven to the data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, CPU memory request present.
REQ-005 SHALL have port req_ready, output, 1, high only in IDLE; a request is accepted when req_valid && req_ready at a clk edge.
REQ-006 SHALL have ports req_we input 1 (1=store), req_size input 2 (00 byte, 01 half, 10 word, 11 reserved), req_unsigned input 1 (zero-extend loads).
REQ-007 SHALL have ports req_addr input 32 (byte address) and req_wdata input 32 (store data, right-aligned for sub-word stores).
REQ-008 SHALL have ports rsp_valid output 1 (one-cycle completion pulse), rsp_rdata output 32 (load result), rsp_err output 1 (misaligned/reserved access).
REQ-009 SHALL have data-memory ports dm_ena, dm_r, dm_w (outputs, 1 each), dm_addr output 32, dm_wdata output 32, dm_rdata input 32 (combinational read data).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-011 SHALL latch req_we, req_size, req_unsigned, req_addr, req_wdata on acceptance; inputs are ignored outside IDLE.
REQ-012 SHALL flag misalignment: half with addr[0]=1, word with addr[1:0]!=00, or size 11; such a request goes IDLE->RESP with rsp_err=1, rsp_rdata=0 and no dm_ena assertion.
REQ-013 SHALL route aligned loads IDLE->LOAD->RESP, word stores IDLE->WRITE->RESP, byte/half stores IDLE->RMW_READ->WRITE->RESP; RESP always returns to IDLE.
REQ-014 SHALL give latency from acceptance edge N to rsp_valid: error N+1, load N+2, word store N+2, sub-word store N+3.
REQ-015 SHALL drive dm_addr = {zeros, latched_addr[WORD_IDX_W+1:2]} and hold it stable throughout LOAD, RMW_READ and WRITE.
REQ-016 SHALL assert dm_ena=1, dm_r=1 in LOAD and RMW_READ, and dm_ena=1, dm_w=1 only during the single WRITE cycle; all three are 0 in IDLE and RESP.
REQ-017 SHALL use little-endian lanes: byte k = bits [8k+7:8k] selected by addr[1:0]; halfword selected by addr[1].
REQ-018 SHALL, in LOAD, register the selected lane sign-extended (req_unsigned=0) or zero-extended (req_unsigned=1) into rsp_rdata.
REQ-019 SHALL, in RMW_READ, register dm_rdata with only the target lane replaced by req_wdata[7:0] or [15:0]; all other bytes are preserved.
REQ-020 SHALL drive dm_wdata = latched req_wdata for word stores and the merged word for sub-word stores.
REQ-021 SHALL drive rsp_rdata=0 for stores; rsp_rdata and rsp_err hold until the next response.
REQ-022 SHALL accept a new request in the cycle after RESP (back-to-back, no gap beyond RESP).

Reset
REQ-023 SHALL on rst force state IDLE asynchronously, with req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, dm_ena=dm_r=dm_w=0, dm_addr=0, dm_wdata=0.
REQ-024 SHALL on rst mid-operation deassert dm_w immediately, discard the pending response, and complete no partial RMW write.

Structure
REQ-025 SHALL place state encoding, size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and lane-select constants in shared package mem_access_pkg.
REQ-026 SHALL implement lane extraction/extension and lane merge in one combinational sub-module lane_mux, instantiated once.

Verification
REQ-027 SHALL cover: word store 0xDEADBEEF at 0x10, then word load 0x10 -> dm_w high exactly one cycle at dm_addr=4, rsp_rdata=0xDEADBEEF at N+2.
REQ-028 SHALL cover: after REQ-027, byte store 0x5A at 0x11, then word load 0x10 -> rsp_valid at N+3 for the store, load returns 0xDEAD5AEF.
REQ-029 SHALL cover: word 0x0000_80F0 at 0x20; signed half load 0x20 -> 0xFFFF80F0, unsigned half load 0x20 -> 0x000080F0, signed byte load 0x21 -> 0xFFFFFF80.
REQ-030 SHALL cover: word load at 0x22 and half store at 0x23 -> rsp_err=1 at N+1, rsp_rdata=0, dm_ena never asserted, memory unchanged.
REQ-031 SHALL cover: rst asserted during RMW_READ of a byte store -> dm_w stays 0, no rsp_valid, req_ready=1 immediately, target word unchanged.
REQ-032 SHALL cover: req_valid held high across a busy load -> second request accepted only on the edge after RESP, both responses correct and in order.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Purpose: shared FSM state, access-size and byte-lane encodings for the memory access unit.
// Latency: none, declarations and a pure combinational helper only.
// Backpressure: not applicable.
package mem_access_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // byte lanes within a little-endian word, selected by addr[1:0]
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    // halfword lanes, selected by addr[1]
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // A request is rejected when its address is not naturally aligned or its size is reserved.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lane_mux.sv
// Purpose: byte/halfword lane extraction with sign/zero extension, and sub-word merge into a read word.
// Latency: purely combinational.
// Backpressure: none; results are valid whenever inputs are.
module lane_mux
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Pick the addressed byte and halfword out of the memory word.
    always_comb begin
        lane_byte = rd_word[7:0];
        case (addr_lo)
            LANE_B1: lane_byte = rd_word[15:8];
            LANE_B2: lane_byte = rd_word[23:16];
            LANE_B3: lane_byte = rd_word[31:24];
            default: lane_byte = rd_word[7:0];
        endcase
        lane_half = (addr_lo[1] == HALF_HI) ? rd_word[31:16] : rd_word[15:0];
    end

    // Right-align the selected lane and extend it to 32 bits.
    always_comb begin
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = zero_ext ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = zero_ext ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_data = rd_word;
        endcase
    end

    // Replace only the target lane of the read word with the low bits of the store data.
    always_comb begin
        merged = rd_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    LANE_B0: merged[7:0]   = wdata[7:0];
                    LANE_B1: merged[15:8]  = wdata[7:0];
                    LANE_B2: merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1] == HALF_HI) merged[31:16] = wdata[15:0];
                else                       merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: CPU load/store unit driving a single-port word memory, with sub-word read-modify-write.
// Latency: accept edge N -> rsp_valid at N+1 (error), N+2 (load, word store), N+3 (sub-word store).
// Backpressure: req_ready high only in IDLE; one request in flight, responses cannot be stalled.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int WORD_IDX_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        dm_ena,
    output logic        dm_r,
    output logic        dm_w,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    state_t                  state;
    state_t                  next_state;
    logic                    lat_we;
    logic [1:0]              lat_size;
    logic                    lat_unsigned;
    logic [1:0]              lat_addr_lo;
    logic [WORD_IDX_W-1:0]   lat_word_idx;
    logic [31:0]             wr_word;
    logic                    req_err;
    logic [31:0]             load_data;
    logic [31:0]             merged;
    logic                    unused_addr_bits;

    // Address bits above the word index never reach the memory.
    assign unused_addr_bits = ^req_addr[31:WORD_IDX_W+2];

    assign req_err  = is_misaligned(req_size, req_addr[1:0]);
    assign dm_addr  = {{(32-WORD_IDX_W){1'b0}}, lat_word_idx};
    assign dm_wdata = wr_word;

    lane_mux u_lane_mux (
        .rd_word   (dm_rdata),
        .addr_lo   (lat_addr_lo),
        .size      (lat_size),
        .zero_ext  (lat_unsigned),
        .wdata     (wr_word),
        .load_data (load_data),
        .merged    (merged)
    );

    // State register; reset drops straight to IDLE so a pending write never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and per-state memory/handshake strobes.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        dm_ena     = 1'b0;
        dm_r       = 1'b0;
        dm_w       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)               next_state = RESP;
                    else if (!req_we)          next_state = LOAD;
                    else if (req_size == SZ_WORD) next_state = WRITE;
                    else                       next_state = RMW_READ;
                end
            end
            LOAD: begin
                dm_ena     = 1'b1;
                dm_r       = 1'b1;
                next_state = RESP;
            end
            RMW_READ: begin
                dm_ena     = 1'b1;
                dm_r       = 1'b1;
                next_state = WRITE;
            end
            WRITE: begin
                dm_ena     = 1'b1;
                dm_w       = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the request on acceptance; the write word becomes the merged word during RMW_READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we       <= 1'b0;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
            lat_addr_lo  <= 2'b00;
            lat_word_idx <= '0;
            wr_word      <= 32'h0;
        end else if (state == IDLE && req_valid) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr_lo  <= req_addr[1:0];
            lat_word_idx <= req_addr[WORD_IDX_W+1:2];
            wr_word      <= req_wdata;
        end else if (state == RMW_READ) begin
            wr_word      <= merged;
        end
    end

    // Response data/error only change on the edge entering RESP, so they hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid && req_err) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b1;
            end else if (state == LOAD) begin
                rsp_rdata <= load_data;
                rsp_err   <= 1'b0;
            end else if (state == WRITE) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= lat_we & 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dm_ena;
    logic        dm_r;
    logic        dm_w;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;
    int ena_cnt = 0;
    int wr_cnt = 0;
    int rsp_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [18];

    mem_access_unit #(.WORD_IDX_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dm_ena       (dm_ena),
        .dm_r         (dm_r),
        .dm_w         (dm_w),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory model: combinational read, write on rising edge
    assign dm_rdata = mem[dm_addr[9:0]];
    always @(posedge clk) begin
        if (dm_ena && dm_w) mem[dm_addr[9:0]] <= dm_wdata;
    end

    // strobe observer, sampled away from the active edge
    always @(negedge clk) begin
        if (dm_ena) ena_cnt++;
        if (dm_w) begin
            wr_cnt++;
            last_wr_addr = dm_addr;
        end
        if (rsp_valid) rsp_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int   w0;
        int   e0;
        int   lat;
        int   exp_wr;
        int   exp_ena;
        logic seen;
        @(negedge clk);
        check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        w0 = wr_cnt;
        e0 = ena_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s timeout actual=no_rsp required=rsp_valid", tag);
        end else begin
            check({tag, " latency"}, lat, v.exp_lat);
            check({tag, " rdata"}, rsp_rdata, v.exp_rdata);
            check({tag, " err"}, {31'h0, rsp_err}, {31'h0, v.exp_err});
        end
        @(negedge clk);
        check({tag, " pulse"}, {31'h0, rsp_valid}, 32'h0);
        exp_wr  = (v.we && !v.exp_err) ? 1 : 0;
        exp_ena = v.exp_err ? 0 : (!v.we ? 1 : (v.size == SZ_WORD ? 1 : 2));
        check({tag, " wr_cycles"}, wr_cnt - w0, exp_wr);
        check({tag, " ena_cycles"}, ena_cnt - e0, exp_ena);
        if (exp_wr == 1) check({tag, " wr_addr"}, last_wr_addr, {2'b00, v.addr[31:2]});
    endtask

    initial begin
        int r0;
        int w0;
        vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2};
        vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2};
        vecs[2]  = '{1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000005A, 32'h0,        1'b0, 3};
        vecs[3]  = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEAD5AEF, 1'b0, 2};
        vecs[4]  = '{1'b1, SZ_WORD, 1'b0, 32'h20, 32'h000080F0, 32'h0,        1'b0, 2};
        vecs[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0,        32'hFFFF80F0, 1'b0, 2};
        vecs[6]  = '{1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0,        32'h000080F0, 1'b0, 2};
        vecs[7]  = '{1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0, 2};
        vecs[8]  = '{1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0,        32'h0,        1'b1, 1};
        vecs[9]  = '{1'b1, SZ_HALF, 1'b0, 32'h23, 32'h0000FFFF, 32'h0,        1'b1, 1};
        vecs[10] = '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,        32'h000080F0, 1'b0, 2};
        vecs[11] = '{1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00001234, 32'h0,        1'b0, 3};
        vecs[12] = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'h12345AEF, 1'b0, 2};
        vecs[13] = '{1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0,        32'h00001234, 1'b0, 2};
        vecs[14] = '{1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,        32'h00000012, 1'b0, 2};
        vecs[15] = '{1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 2};
        vecs[16] = '{1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1};
        vecs[17] = '{1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0,        32'h0,        1'b0, 2};

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;

        // reset state
        #12;
        check("rst req_ready", {31'h0, req_ready}, 32'h1);
        check("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst dm_strobes", {29'h0, dm_ena, dm_r, dm_w}, 32'h0);
        check("rst dm_addr", dm_addr, 32'h0);
        check("rst dm_wdata", dm_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_req(vecs[i], $sformatf("v%0d", i));
        end
        check("misaligned store left word 8", mem[8], 32'h000080F0);

        // held req_valid across a busy load: second request taken only after RESP
        @(negedge clk);
        check("b2b ready0", {31'h0, req_ready}, 32'h1);
        req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        r0 = rsp_cnt;
        @(posedge clk);
        #1 req_addr = 32'h20;
        @(negedge clk);
        check("b2b c1 ready", {31'h0, req_ready}, 32'h0);
        check("b2b c1 rsp", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        check("b2b c2 rsp", {31'h0, rsp_valid}, 32'h1);
        check("b2b c2 rdata", rsp_rdata, 32'h12345AEF);
        check("b2b c2 ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("b2b c3 ready", {31'h0, req_ready}, 32'h1);
        check("b2b c3 rsp", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        check("b2b c4 ready", {31'h0, req_ready}, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b c5 rsp", {31'h0, rsp_valid}, 32'h1);
        check("b2b c5 rdata", rsp_rdata, 32'h000080F0);
        check("b2b c5 err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        check("b2b rsp count", rsp_cnt - r0, 2);

        // reset during RMW_READ of a byte store
        do_req('{1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2}, "rmw_pre");
        @(negedge clk);
        req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0; req_addr = 32'h41; req_wdata = 32'h11;
        req_valid = 1'b1;
        r0 = rsp_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rmw in read", {30'h0, dm_r, dm_w}, 32'h2);
        #2 rst = 1'b1;
        #1;
        check("rmw rst ready", {31'h0, req_ready}, 32'h1);
        check("rmw rst dm_w", {31'h0, dm_w}, 32'h0);
        check("rmw rst rsp", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rmw no rsp", rsp_cnt - r0, 0);
        check("rmw no write", wr_cnt - w0, 0);
        check("rmw word kept", mem[16], 32'hCAFEF00D);
        do_req('{1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2}, "rmw_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
